// File: rtl/tinydfu_boot_seq.sv
// Boot sequencer for a DFU bootloader: reset hold, autoboot countdown, DFU idle, USB detach gap, boot.
// Optional user-button detach path is enabled by defining BOOT_SEQ_BTN_EN.
module tinydfu_boot_seq #(
  parameter int unsigned RESET_HOLD     = 65535,
  parameter int unsigned CLK_HZ         = 12000000,
  parameter int unsigned BOOT_TIMEOUT_S = 5,
  parameter int unsigned DETACH_GAP     = 4095
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] dfu_state,
  input  logic       dfu_detach,
`ifdef BOOT_SEQ_BTN_EN
  input  logic       boot_btn,
`endif
  output logic       core_reset,
  output logic       usb_pull_en,
  output logic       boot_now,
  output logic       autoboot_active,
  output logic [2:0] seq_state
);

  localparam logic [31:0] BOOT_CYCLES = 32'(CLK_HZ * BOOT_TIMEOUT_S);
  localparam logic [31:0] BOOT_LOAD   = (BOOT_CYCLES == 32'd0) ? 32'd0 : BOOT_CYCLES - 32'd1;
  localparam logic [15:0] HOLD_LOAD   = 16'(RESET_HOLD - 1);
  localparam logic [15:0] GAP_LOAD    = 16'(DETACH_GAP - 1);
  localparam logic        AUTOBOOT_EN = (BOOT_TIMEOUT_S != 0);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_DFU    = 3'd2,
    S_DETACH = 3'd3,
    S_BOOT   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_hold_cnt;
  logic [15:0] r_det_cnt;
  logic [31:0] r_boot_cnt;
  logic        w_btn_det;
  logic        w_detach_req;

`ifdef BOOT_SEQ_BTN_EN
  logic [15:0] r_deb_cnt;

  // Saturating press-length counter; a full-scale count acts as a detach request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_deb_cnt <= 16'd0;
    end else if (!boot_btn) begin
      r_deb_cnt <= 16'd0;
    end else if (r_deb_cnt != 16'hFFFF) begin
      r_deb_cnt <= r_deb_cnt + 16'd1;
    end
  end

  assign w_btn_det = (r_deb_cnt == 16'hFFFF);
`else
  assign w_btn_det = 1'b0;
`endif

  assign w_detach_req = dfu_detach | w_btn_det;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: begin
        if (r_hold_cnt == 16'd0) w_next = AUTOBOOT_EN ? S_WAIT : S_DFU;
      end
      S_WAIT: begin
        // Detach wins over a host cancel, which wins over the timeout.
        if (w_detach_req)               w_next = S_DETACH;
        else if (dfu_state > 8'h02)     w_next = S_DFU;
        else if (r_boot_cnt == 32'd0)   w_next = S_BOOT;
      end
      S_DFU: begin
        if (w_detach_req) w_next = S_DETACH;
      end
      S_DETACH: begin
        if (r_det_cnt == 16'd0) w_next = S_BOOT;
      end
      S_BOOT:  w_next = S_BOOT;
      default: w_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_RESET;
      r_hold_cnt <= HOLD_LOAD;
      r_boot_cnt <= 32'd0;
      r_det_cnt  <= 16'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RESET && r_hold_cnt != 16'd0) r_hold_cnt <= r_hold_cnt - 16'd1;

      if (r_state != S_WAIT && w_next == S_WAIT)
        r_boot_cnt <= BOOT_LOAD;
      else if (r_state == S_WAIT && w_next == S_WAIT && r_boot_cnt != 32'd0)
        r_boot_cnt <= r_boot_cnt - 32'd1;

      if (r_state != S_DETACH && w_next == S_DETACH)
        r_det_cnt <= GAP_LOAD;
      else if (r_state == S_DETACH && r_det_cnt != 16'd0)
        r_det_cnt <= r_det_cnt - 16'd1;
    end
  end

  assign core_reset      = (r_state == S_RESET);
  assign usb_pull_en     = (r_state == S_WAIT) || (r_state == S_DFU);
  assign boot_now        = (r_state == S_BOOT);
  assign autoboot_active = (r_state == S_WAIT);
  assign seq_state       = r_state;

endmodule

// File: tb/tb_tinydfu_boot_seq.sv
// Self-checking bench for tinydfu_boot_seq: directed sequence checks plus a randomized run
// against a timeline-based reference model. Button tests run when BOOT_SEQ_BTN_EN is defined.
module tb_tinydfu_boot_seq;
  localparam int RESET_HOLD     = 16;
  localparam int CLK_HZ         = 100;
  localparam int BOOT_TIMEOUT_S = 1;
  localparam int DETACH_GAP     = 8;
  localparam int BOOT_CYCLES    = CLK_HZ * BOOT_TIMEOUT_S;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] dfu_state = 8'd0;
  logic       dfu_detach = 1'b0;
  logic       boot_btn = 1'b0;
  logic       core_reset;
  logic       usb_pull_en;
  logic       boot_now;
  logic       autoboot_active;
  logic [2:0] seq_state;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Reference model: state number plus the cycle on which it was entered.
  int m_state = 0;
  int m_entry = 0;
  int m_btn_run = 0;

  always #5 clk = ~clk;

  tinydfu_boot_seq #(
    .RESET_HOLD(RESET_HOLD), .CLK_HZ(CLK_HZ),
    .BOOT_TIMEOUT_S(BOOT_TIMEOUT_S), .DETACH_GAP(DETACH_GAP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .dfu_state(dfu_state),
    .dfu_detach(dfu_detach),
`ifdef BOOT_SEQ_BTN_EN
    .boot_btn(boot_btn),
`endif
    .core_reset(core_reset),
    .usb_pull_en(usb_pull_en),
    .boot_now(boot_now),
    .autoboot_active(autoboot_active),
    .seq_state(seq_state)
  );

  function void model_step(input int k, input logic rst_n, input logic det,
                           input logic [7:0] ds, input logic btn);
    int  elapsed;
    int  nxt;
    logic det_any;
    if (!rst_n) begin
      m_state = 0; m_entry = k + 1; m_btn_run = 0;
      return;
    end
    elapsed = k - m_entry + 1;
`ifdef BOOT_SEQ_BTN_EN
    det_any = det || (m_btn_run >= 65535);
`else
    det_any = det;
`endif
    nxt = m_state;
    case (m_state)
      0: if (elapsed >= RESET_HOLD) nxt = (BOOT_TIMEOUT_S > 0) ? 1 : 2;
      1: begin
        if (det_any)                     nxt = 3;
        else if (ds > 8'h02)             nxt = 2;
        else if (elapsed >= BOOT_CYCLES) nxt = 4;
      end
      2: if (det_any) nxt = 3;
      3: if (elapsed >= DETACH_GAP) nxt = 4;
      default: nxt = m_state;
    endcase
    if (nxt != m_state) begin
      m_state = nxt; m_entry = k + 1;
    end
    m_btn_run = btn ? ((m_btn_run < 65535) ? m_btn_run + 1 : 65535) : 0;
  endfunction

  function logic [6:0] model_outs();
    return {m_state == 0, (m_state == 1) || (m_state == 2), m_state == 4, m_state == 1, 3'(m_state)};
  endfunction

  task apply_reset();
    @(negedge clk);
    resetn = 1'b0; dfu_detach = 1'b0; dfu_state = 8'd0; boot_btn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    cyc = 0; m_state = 0; m_entry = 0; m_btn_run = 0;
  endtask

  task next_cycle();
    model_step(cyc, resetn, dfu_detach, dfu_state, boot_btn);
    @(negedge clk);
    cyc++;
  endtask

  task test_reset();
    logic [6:0] obs;
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    obs = {core_reset, usb_pull_en, boot_now, autoboot_active, seq_state};
    n_total++;
    if (obs !== 7'b1000000) $display("FAIL reset_held: got %b want 1000000", obs);
    else n_pass++;
    resetn = 1'b1;
    cyc = 0; m_state = 0; m_entry = 0; m_btn_run = 0;
    obs = {core_reset, usb_pull_en, boot_now, autoboot_active, seq_state};
    n_total++;
    if (obs !== 7'b1000000) $display("FAIL reset_first_cycle: got %b want 1000000", obs);
    else n_pass++;
    next_cycle();
    obs = {core_reset, usb_pull_en, boot_now, autoboot_active, seq_state};
    n_total++;
    if (obs !== 7'b1000000) $display("FAIL reset_cycle1: got %b want 1000000", obs);
    else n_pass++;
  endtask

  task test_autoboot();
    logic [6:0] obs, exp;
    apply_reset();
    for (int c = 0; c <= 140; c++) begin
      exp = {c < 16, (c >= 16) && (c < 116), c >= 116, (c >= 16) && (c < 116),
             (c < 16) ? 3'd0 : ((c < 116) ? 3'd1 : 3'd4)};
      obs = {core_reset, usb_pull_en, boot_now, autoboot_active, seq_state};
      n_total++;
      if (obs !== exp) $display("FAIL autoboot cycle %0d: got %b want %b", c, obs, exp);
      else n_pass++;
      next_cycle();
    end
  endtask

  task test_cancel();
    int bad;
    apply_reset();
    while (cyc < 40) next_cycle();
    dfu_state = 8'h05;
    next_cycle();
    n_total++;
    if ({seq_state, autoboot_active, usb_pull_en} !== {3'd2, 1'b0, 1'b1})
      $display("FAIL cancel_enter_dfu: got state=%0d auto=%b pull=%b want 2/0/1",
               seq_state, autoboot_active, usb_pull_en);
    else n_pass++;
    dfu_state = 8'h00;
    bad = 0;
    repeat (10000) begin
      next_cycle();
      if (boot_now !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0 || seq_state !== 3'd2)
      $display("FAIL cancel_no_boot: %0d cycles with boot_now, final state=%0d want 0 and 2", bad, seq_state);
    else n_pass++;
  endtask

  task test_detach();
    logic [4:0] obs, exp;
    apply_reset();
    while (cyc < 40) next_cycle();
    dfu_state = 8'h05;
    next_cycle();
    dfu_state = 8'h00;
    while (cyc < 200) next_cycle();
    dfu_detach = 1'b1;
    next_cycle();
    dfu_detach = 1'b0;
    for (int c = 201; c <= 212; c++) begin
      exp = {1'b0, c >= 209, (c < 209) ? 3'd3 : 3'd4};
      obs = {usb_pull_en, boot_now, seq_state};
      n_total++;
      if (obs !== exp) $display("FAIL detach cycle %0d: got %b want %b", c, obs, exp);
      else n_pass++;
      next_cycle();
    end
  endtask

  task test_priority();
    apply_reset();
    while (cyc < 115) next_cycle();
    n_total++;
    if (autoboot_active !== 1'b1) $display("FAIL prio_last_wait: got %b want 1", autoboot_active);
    else n_pass++;
    dfu_detach = 1'b1; dfu_state = 8'h05;
    next_cycle();
    dfu_detach = 1'b0; dfu_state = 8'h00;
    n_total++;
    if (seq_state !== 3'd3) $display("FAIL prio_detach_over_all: got %0d want 3", seq_state);
    else n_pass++;

    apply_reset();
    while (cyc < 115) next_cycle();
    dfu_state = 8'h05;
    next_cycle();
    dfu_state = 8'h00;
    n_total++;
    if (seq_state !== 3'd2) $display("FAIL prio_cancel_over_timeout: got %0d want 2", seq_state);
    else n_pass++;

    apply_reset();
    while (cyc < 60) next_cycle();
    dfu_detach = 1'b1; dfu_state = 8'h03;
    next_cycle();
    dfu_detach = 1'b0; dfu_state = 8'h00;
    n_total++;
    if (seq_state !== 3'd3) $display("FAIL prio_detach_over_cancel: got %0d want 3", seq_state);
    else n_pass++;
  endtask

  task test_reset_in_boot();
    logic [6:0] obs, exp;
    apply_reset();
    while (cyc < 120) next_cycle();
    n_total++;
    if (boot_now !== 1'b1) $display("FAIL rib_in_boot: got %b want 1", boot_now);
    else n_pass++;
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    n_total++;
    if ({boot_now, core_reset, seq_state} !== {1'b0, 1'b1, 3'd0})
      $display("FAIL rib_after_reset: got boot=%b core=%b state=%0d want 0/1/0", boot_now, core_reset, seq_state);
    else n_pass++;
    cyc = 0; m_entry = 0;
    for (int c = 0; c <= 125; c++) begin
      exp = {c < 16, (c >= 16) && (c < 116), c >= 116, (c >= 16) && (c < 116),
             (c < 16) ? 3'd0 : ((c < 116) ? 3'd1 : 3'd4)};
      obs = {core_reset, usb_pull_en, boot_now, autoboot_active, seq_state};
      n_total++;
      if (obs !== exp) $display("FAIL rib_restart cycle %0d: got %b want %b", c, obs, exp);
      else n_pass++;
      next_cycle();
    end
  endtask

  task test_random();
    logic [6:0] obs, exp;
    for (int ep = 0; ep < 10; ep++) begin
      apply_reset();
      for (int i = 0; i < 300; i++) begin
        exp = model_outs();
        obs = {core_reset, usb_pull_en, boot_now, autoboot_active, seq_state};
        n_total++;
        if (obs !== exp) $display("FAIL random ep %0d cycle %0d: got %b want %b", ep, i, obs, exp);
        else n_pass++;
        resetn     = ($urandom_range(0, 399) != 0);
        dfu_detach = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, (ep % 2 == 0) ? 60 : 250) == 0)
          dfu_state = 8'($urandom_range(3, 255));
        else
          dfu_state = 8'($urandom_range(0, 2));
`ifdef BOOT_SEQ_BTN_EN
        boot_btn = ($urandom_range(0, 3) != 0);
`endif
        next_cycle();
      end
      resetn = 1'b1; dfu_detach = 1'b0; dfu_state = 8'd0; boot_btn = 1'b0;
    end
  endtask

`ifdef BOOT_SEQ_BTN_EN
  task test_button();
    int p;
    apply_reset();
    while (cyc < 40) next_cycle();
    dfu_state = 8'h05;
    next_cycle();
    dfu_state = 8'h00;
    boot_btn = 1'b1;
    repeat (1000) next_cycle();
    boot_btn = 1'b0;
    repeat (20) next_cycle();
    n_total++;
    if (seq_state !== 3'd2) $display("FAIL btn_short_press: got %0d want 2", seq_state);
    else n_pass++;
    boot_btn = 1'b1;
    p = cyc;
    while (cyc < p + 65535) next_cycle();
    n_total++;
    if (seq_state !== 3'd2 || model_outs() !== 7'b0100010)
      $display("FAIL btn_before_full: got %0d want 2", seq_state);
    else n_pass++;
    next_cycle();
    boot_btn = 1'b0;
    n_total++;
    if (seq_state !== 3'd3) $display("FAIL btn_long_press: got %0d want 3", seq_state);
    else n_pass++;
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_autoboot();
    test_cancel();
    test_detach();
    test_priority();
    test_reset_in_boot();
    test_random();
`ifdef BOOT_SEQ_BTN_EN
    test_button();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tinydfu_boot_seq.md
TINYDFU_BOOT_SEQ -- requirements
Module: tinydfu_boot_seq

Interface
REQ-001 SHALL have parameter RESET_HOLD, default 65535, the number of cycles core_reset is held after reset release (legal range 1..65535).
REQ-002 SHALL have parameter CLK_HZ, default 12000000, the clk frequency in Hz.
REQ-003 SHALL have parameter BOOT_TIMEOUT_S, default 5, the autoboot timeout in seconds; 0 disables autoboot.
REQ-004 SHALL have parameter DETACH_GAP, default 4095, the number of cycles the USB pull-up is dropped before boot (legal range 1..65535).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock (12 MHz domain).
REQ-006 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port dfu_state, input, 8 bits: the DFU class state from the DFU core.
REQ-008 SHALL have port dfu_detach, input, 1 bit: the detach request from the DFU core (level, sampled each cycle).
REQ-009 SHALL have port boot_btn, input, 1 bit: the user button, active-high, already synchronised to clk; present only when BOOT_SEQ_BTN_EN is defined.
REQ-010 SHALL have port core_reset, output, 1 bit: active-high reset to the DFU core.
REQ-011 SHALL have port usb_pull_en, output, 1 bit: enables the USB host-detect pull-up.
REQ-012 SHALL have port boot_now, output, 1 bit: sticky request to reconfigure into the user image.
REQ-013 SHALL have port autoboot_active, output, 1 bit: high while the autoboot countdown is running.
REQ-014 SHALL have port seq_state, output, 3 bits: the current FSM state encoding, for LED and debug use.

Function
REQ-015 SHALL implement a Moore FSM with states S_RESET=0, S_WAIT=1, S_DFU=2, S_DETACH=3, S_BOOT=4; all outputs SHALL be decoded from registered state only.
REQ-016 SHALL hold S_RESET for exactly RESET_HOLD cycles, then enter S_WAIT if BOOT_TIMEOUT_S>0, otherwise enter S_DFU.
REQ-017 SHALL compute BOOT_CYCLES = CLK_HZ*BOOT_TIMEOUT_S as a 32-bit constant and load a 32-bit down-counter with BOOT_CYCLES-1 on entry to S_WAIT.
REQ-018 SHALL remain in S_WAIT for at most BOOT_CYCLES cycles; when the counter reaches 0 in S_WAIT, the next state SHALL be S_BOOT.
REQ-019 SHALL, in S_WAIT, treat dfu_state > 8'h02 as a cancel condition and go to S_DFU next cycle, with the counter frozen.
REQ-020 SHALL, in S_WAIT or S_DFU, go to S_DETACH next cycle when dfu_detach=1.
REQ-021 SHALL apply this priority within S_WAIT for same-cycle events: detach > cancel > timeout.
REQ-022 SHALL hold S_DETACH for exactly DETACH_GAP cycles, then enter S_BOOT.
REQ-023 SHALL treat S_BOOT as terminal; only resetn=0 SHALL leave it.
REQ-024 SHALL ignore dfu_detach and dfu_state while in S_RESET, S_DETACH or S_BOOT.
REQ-025 SHALL drive core_reset=1 only in S_RESET.
REQ-026 SHALL drive usb_pull_en=1 only in S_WAIT and S_DFU.
REQ-027 SHALL drive boot_now=1 only in S_BOOT.
REQ-028 SHALL drive autoboot_active=1 only in S_WAIT.
REQ-029 SHALL keep the counters saturating; none SHALL wrap below 0.

Reset
REQ-030 SHALL, on resetn=0 sampled at a clk edge, enter S_RESET, load the hold counter with RESET_HOLD-1, and clear the boot, detach and debounce counters; this SHALL also apply when reset arrives mid-sequence, including in S_BOOT.
REQ-031 SHALL hold these output values during reset and on the first cycle after: core_reset=1, usb_pull_en=0, boot_now=0, autoboot_active=0, seq_state=0.

Configuration
REQ-032 SHALL, when macro BOOT_SEQ_BTN_EN is defined, include boot_btn and a 16-bit debounce counter that counts while boot_btn=1 and clears when boot_btn=0.
REQ-033 SHALL, with BOOT_SEQ_BTN_EN defined, treat the debounce counter reaching 16'hFFFF in S_WAIT or S_DFU as a detach (same priority as dfu_detach).
REQ-034 SHALL, without BOOT_SEQ_BTN_EN, omit boot_btn and the debounce logic, with behaviour identical to boot_btn tied to 0.

Verification (RESET_HOLD=16, CLK_HZ=100, BOOT_TIMEOUT_S=1, DETACH_GAP=8)
REQ-035 SHALL check: release resetn, no activity -> core_reset high for cycles 0-15, usb_pull_en high for cycles 16-115, boot_now high from cycle 116 onward.
REQ-036 SHALL check: dfu_state=8'h05 at cycle 40 -> S_DFU at cycle 41, autoboot_active=0, boot_now stays 0 for 10000 cycles.
REQ-037 SHALL check: in S_DFU, a dfu_detach pulse at cycle 200 -> usb_pull_en=0 for cycles 201-208, boot_now=1 from cycle 209.
REQ-038 SHALL check: dfu_detach=1 and dfu_state=8'h05 in the same cycle as the timeout -> S_DETACH is entered, not S_BOOT or S_DFU.
REQ-039 SHALL check: resetn=0 for one cycle while in S_BOOT -> boot_now=0 and core_reset=1 on the next cycle, and the full sequence restarts.
REQ-040 SHALL check, with BOOT_SEQ_BTN_EN defined: boot_btn held high for 65535 cycles in S_DFU -> S_DETACH; a 1000-cycle press -> no effect.
